// File: rtl/grf.sv
// rtl/grf.sv - MIPS general register file with WB bypass and commit trace FIFO
module grf #(
    parameter int TRACE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_write_en_in,
    input  logic [4:0]  reg_write_addr_in,
    input  logic [31:0] reg_write_data_in,
    input  logic [31:0] pc_in,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_addr,
    output logic [31:0] trace_data,
    output logic        trace_overflow
);
    localparam int PW = $clog2(TRACE_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(TRACE_DEPTH);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [31:0] fpc_q   [TRACE_DEPTH];
    logic [31:0] fpc_d   [TRACE_DEPTH];
    logic [4:0]  faddr_q [TRACE_DEPTH];
    logic [4:0]  faddr_d [TRACE_DEPTH];
    logic [31:0] fdata_q [TRACE_DEPTH];
    logic [31:0] fdata_d [TRACE_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;

    logic commit;
    logic full;
    logic pop;
    logic push;

    // Writes to $0 are discarded outright, so they never reach storage or the trace.
    assign commit = reg_write_en_in && (reg_write_addr_in != 5'd0);
    assign full   = (count_q == DEPTH_C);
    assign pop    = (count_q != '0) && trace_ready;
    assign push   = commit && (!full || pop);

    always_comb begin
        rs_data = 32'd0;
        if (rs_addr != 5'd0) begin
            if (commit && (reg_write_addr_in == rs_addr)) begin
                rs_data = reg_write_data_in;
            end else begin
                rs_data = regs_q[rs_addr];
            end
        end
    end

    always_comb begin
        rt_data = 32'd0;
        if (rt_addr != 5'd0) begin
            if (commit && (reg_write_addr_in == rt_addr)) begin
                rt_data = reg_write_data_in;
            end else begin
                rt_data = regs_q[rt_addr];
            end
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            regs_d[reg_write_addr_in] = reg_write_data_in;
        end
    end

    always_comb begin
        fpc_d      = fpc_q;
        faddr_d    = faddr_q;
        fdata_d    = fdata_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
        overflow_d = overflow_q | (commit && full && !pop);
        if (push) begin
            fpc_d[wr_ptr_q]   = pc_in;
            faddr_d[wr_ptr_q] = reg_write_addr_in;
            fdata_d[wr_ptr_q] = reg_write_data_in;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                fpc_q[i]   <= 32'd0;
                faddr_q[i] <= 5'd0;
                fdata_q[i] <= 32'd0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            fpc_q      <= fpc_d;
            faddr_q    <= faddr_d;
            fdata_q    <= fdata_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign trace_valid    = (count_q != '0);
    assign trace_pc       = fpc_q[rd_ptr_q];
    assign trace_addr     = faddr_q[rd_ptr_q];
    assign trace_data     = fdata_q[rd_ptr_q];
    assign trace_overflow = overflow_q;
endmodule

// File: tb/tb_grf.sv
// tb/tb_grf.sv - self-checking bench for grf: read vectors plus trace scoreboard
module tb_grf;
    logic        clk;
    logic        rst_n;
    logic        reg_write_en_in;
    logic [4:0]  reg_write_addr_in;
    logic [31:0] reg_write_data_in;
    logic [31:0] pc_in;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic        trace_overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        rdy;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    entry_t tq[$];
    logic   m_ov;

    grf #(.TRACE_DEPTH(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .reg_write_en_in   (reg_write_en_in),
        .reg_write_addr_in (reg_write_addr_in),
        .reg_write_data_in (reg_write_data_in),
        .pc_in             (pc_in),
        .rs_addr           (rs_addr),
        .rt_addr           (rt_addr),
        .rs_data           (rs_data),
        .rt_data           (rt_data),
        .trace_valid       (trace_valid),
        .trace_ready       (trace_ready),
        .trace_pc          (trace_pc),
        .trace_addr        (trace_addr),
        .trace_data        (trace_data),
        .trace_overflow    (trace_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drives one cycle after a falling edge, checks outputs, then advances the scoreboard.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [4:0] ra, input logic [4:0] rb,
                         input logic rdy, input logic [31:0] ers, input logic [31:0] ert);
        logic   pop;
        logic   full;
        entry_t e;
        reg_write_en_in   = we;
        reg_write_addr_in = wa;
        reg_write_data_in = wd;
        pc_in             = pc;
        rs_addr           = ra;
        rt_addr           = rb;
        trace_ready       = rdy;
        #1;
        chk("rs_data", rs_data, ers);
        chk("rt_data", rt_data, ert);
        chk("trace_valid", 32'(trace_valid), 32'(tq.size() != 0));
        chk("trace_overflow", 32'(trace_overflow), 32'(m_ov));
        if (tq.size() != 0) begin
            chk("trace_pc", trace_pc, tq[0].pc);
            chk("trace_addr", 32'(trace_addr), 32'(tq[0].addr));
            chk("trace_data", trace_data, tq[0].data);
        end
        pop  = (tq.size() != 0) && rdy;
        full = (tq.size() == 4);
        if (pop) void'(tq.pop_front());
        if (we && wa != 5'd0) begin
            if (!full || pop) begin
                e.pc = pc; e.addr = wa; e.data = wd;
                tq.push_back(e);
            end else begin
                m_ov = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        tq.delete();
        m_ov = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 32'h3000, 5'd5,  5'd0, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        32'h0,    5'd5,  5'd0, 1'b1, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 32'h3010, 5'd0,  5'd5, 1'b1, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        32'h0,    5'd0,  5'd0, 1'b1, 32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd7,  32'h1,        32'h3004, 5'd7,  5'd0, 1'b1, 32'h1,        32'h0};
        vecs[5] = '{1'b1, 5'd7,  32'h12345678, 32'h3008, 5'd6,  5'd7, 1'b1, 32'h0,        32'h12345678};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        32'h0,    5'd7,  5'd6, 1'b1, 32'h12345678, 32'h0};
        vecs[7] = '{1'b1, 5'd31, 32'hA5A5A5A5, 32'h300C, 5'd31, 5'd5, 1'b1, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[8] = '{1'b0, 5'd7,  32'h0000FFFF, 32'h0,    5'd7,  5'd31,1'b1, 32'h12345678, 32'hA5A5A5A5};

        m_ov = 1'b0;
        rst_n = 1'b0;
        reg_write_en_in = 1'b0; reg_write_addr_in = '0; reg_write_data_in = '0;
        pc_in = '0; rs_addr = 5'd5; rt_addr = 5'd31; trace_ready = 1'b0;
        #1;
        chk("reset_valid", 32'(trace_valid), 32'd0);
        chk("reset_overflow", 32'(trace_overflow), 32'd0);
        chk("reset_head_pc", trace_pc, 32'd0);
        chk("reset_head_data", trace_data, 32'd0);
        chk("reset_rs", rs_data, 32'd0);
        chk("reset_rt", rt_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].pc, vecs[i].ra, vecs[i].rb,
                  vecs[i].rdy, vecs[i].exp_rs, vecs[i].exp_rt);
        end

        // Overflow: five commits into a depth-4 FIFO with the consumer stalled.
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 5'(i), 32'h100 + 32'(i), 32'h4000 + 32'(4*i), 5'(i), 5'd0, 1'b0,
                  32'h100 + 32'(i), 32'h0);
        end
        cycle(1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd4, 1'b0, 32'h105, 32'h104);
        chk("overflow_set", 32'(trace_overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 32'(trace_addr), 32'(i));
            cycle(1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'd0, 1'b1, 32'h100 + 32'(i), 32'h0);
        end
        cycle(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);

        // Full FIFO with simultaneous push and pop, long enough to wrap the pointers twice.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 5'(8+i), 32'h200 + 32'(i), 32'h5000 + 32'(4*i), 5'd0, 5'd0, 1'b0,
                  32'h0, 32'h0);
        end
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 5'(16+i), 32'h300 + 32'(i), 32'h6000 + 32'(4*i), 5'(16+i), 5'd9, 1'b1,
                  32'h300 + 32'(i), 32'h201);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 5'd0, 32'h0, 32'h0, 5'd24, 5'd0, 1'b1, 32'h308, 32'h0);
        end
        cycle(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
        chk("no_overflow_push_pop", 32'(trace_overflow), 32'd0);

        // Asynchronous reset between edges while three entries are queued.
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, 5'(i), 32'h700 + 32'(i), 32'h7000 + 32'(4*i), 5'd0, 5'd0, 1'b0,
                  32'h0, 32'h0);
        end
        reg_write_en_in = 1'b0;
        rs_addr = 5'd1;
        rt_addr = 5'd2;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(trace_valid), 32'd0);
        chk("async_overflow", 32'(trace_overflow), 32'd0);
        chk("async_rs", rs_data, 32'd0);
        chk("async_rt", rt_data, 32'd0);
        chk("async_head_addr", 32'(trace_addr), 32'd0);
        tq.delete();
        m_ov = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 5'd3, 32'h77, 32'h8000, 5'd3, 5'd1, 1'b0, 32'h77, 32'h0);
        cycle(1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd2, 1'b1, 32'h77, 32'h0);
        cycle(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
